ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter INSTR_W, default 9, instruction width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins execution.
REQ-006 SHALL have port instr_valid  input  1  instruction memory has instr ready (fetch handshake).
REQ-007 SHALL have port instr  input  INSTR_W  fetched instruction: [8:7] class, [6:3] funct, [2:0] operand.
REQ-008 SHALL have port zero  input  1  ALU zero flag, sampled in EXEC.
REQ-009 SHALL have ports alu_op  output  2  and funct_bit  output  4, driving the ALU decoder's ALUOp/FunctBit.
REQ-010 SHALL have outputs, 1 bit each: pc_clr, pc_inc, pc_load (branch target), ir_load, reg_we, mem_re, mem_we, halted.
REQ-011 SHALL have port retired  output  CNT_W  count of retired instructions.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 IDLE: on start, pulse pc_clr for one cycle and go to FETCH; otherwise stay.
REQ-014 FETCH: wait while instr_valid=0; on instr_valid=1 assert ir_load, capture instr into IR, go to DECODE.
REQ-015 DECODE: if IR equals HALT_INSTR (all ones), go to HALT; otherwise go to EXEC.
REQ-016 alu_op SHALL equal IR[8:7] and funct_bit SHALL equal IR[6:3] from DECODE onward; both SHALL hold until the next ir_load.
REQ-017 EXEC, class 00 or 01: go to WB.
REQ-018 EXEC, class 10 with funct[3]=0 (EQ compare): if zero=1, assert pc_load; otherwise assert pc_inc; go to FETCH and retire.
REQ-019 EXEC, class 10 with funct[3]=1 (unconditional): assert pc_load, go to FETCH and retire.
REQ-020 EXEC, class 11: go to MEM.
REQ-021 MEM: if funct[0]=0 (load), assert mem_re and go to WB; if funct[0]=1 (store), assert mem_we and pc_inc, go to FETCH and retire.
REQ-022 WB: assert reg_we and pc_inc for exactly one cycle, go to FETCH and retire.
REQ-023 All strobes (pc_*, ir_load, reg_we, mem_re, mem_we) SHALL be Moore outputs, high for exactly one cycle per use, and never two of pc_clr/pc_inc/pc_load together.
REQ-024 Latency per instruction: R/I 4 cycles, branch 3, store 4, load 5, measured from FETCH entry with instr_valid already high.
REQ-025 HALT: halted=1; stay until start, then pulse pc_clr and go to FETCH; retired SHALL NOT clear.
REQ-026 start SHALL be ignored in every state except IDLE and HALT.
REQ-027 retired SHALL increment by 1 on each retire and saturate at all ones; it SHALL NOT wrap.

Reset
REQ-028 reset SHALL immediately force IDLE, IR=0, alu_op=0, funct_bit=0, retired=0, and all strobes and halted to 0, including mid-instruction.
REQ-029 After reset deassertion, the block SHALL stay in IDLE until start.

Configuration
REQ-030 Macro CTRL_PERF_CNT_EN defined: retired counter implemented per REQ-027.
REQ-031 CTRL_PERF_CNT_EN undefined: no counter registers; retired SHALL be tied to 0; all other behaviour unchanged.

Structure
REQ-032 Package ctrl_pkg SHALL hold the state enum, class constants (CLS_R=00, CLS_I=01, CLS_BR=10, CLS_MEM=11), and HALT_INSTR.
REQ-033 The counter SHALL be a sub-module named retire_cnt, instantiated only under CTRL_PERF_CNT_EN.

Verification
REQ-034 reset, start, instr=9'h008 (R add) with instr_valid=1 -> ir_load, then alu_op=00 and funct_bit=0001, reg_we in cycle 4, retired=1.
REQ-035 instr=9'h100 (EQ branch) with zero=1 -> pc_load once and no reg_we; same instruction with zero=0 -> pc_inc once.
REQ-036 instr=9'h180 (load), then 9'h188 (store) -> load: mem_re then reg_we; store: mem_we with no reg_we; retired=2.
REQ-037 instr_valid held 0 for 5 cycles in FETCH -> FSM stays in FETCH, no strobes; on instr_valid=1, normal flow resumes.
REQ-038 instr=9'h1FF -> halted=1; start in HALT -> pc_clr pulse and return to FETCH; reset asserted during MEM -> all outputs 0 in the same cycle, state IDLE.
REQ-039 CTRL_PERF_CNT_EN with CNT_W=2, 5 retires -> retired=3; without the macro -> retired=0 throughout.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared types and constants for the ctrl_fsm instruction sequencer.
//   state_e    : sequencer states
//   CLS_*      : instruction class field values (instr[8:7])
//   HALT_INSTR : all-ones instruction that stops the sequencer
//   strobe_t   : one-cycle control strobes, registered as a group
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   localparam logic [1:0] CLS_R   = 2'b00;
   localparam logic [1:0] CLS_I   = 2'b01;
   localparam logic [1:0] CLS_BR  = 2'b10;
   localparam logic [1:0] CLS_MEM = 2'b11;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   typedef struct packed {
      logic pc_clr;
      logic pc_inc;
      logic pc_load;
      logic ir_load;
      logic reg_we;
      logic mem_re;
      logic mem_we;
   } strobe_t;

endpackage

// File: rtl/retire_cnt.sv
// retire_cnt -- saturating retired-instruction counter.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : one-cycle retire pulse
//   count      : retire count, sticks at all ones instead of wrapping
module retire_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !(&count_q)) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
//   clk, reset        : clock, asynchronous active-high reset
//   start             : begin execution (honoured only in IDLE and HALT)
//   instr_valid/instr : fetch handshake; instr = {class[8:7], funct[6:3], operand[2:0]}
//   zero              : ALU zero flag, sampled in EXEC for EQ branches
//   alu_op/funct_bit  : IR class/funct fields, stable from DECODE until the next fetch
//   pc_*, ir_load, reg_we, mem_re, mem_we : one-cycle registered strobes
//   halted            : high while in HALT
//   retired           : saturating retire count; only built when CTRL_PERF_CNT_EN is
//                       defined, otherwise tied to zero
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int INSTR_W = 9,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   input  logic               zero,
   output logic [1:0]         alu_op,
   output logic [3:0]         funct_bit,
   output logic               pc_clr,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               ir_load,
   output logic               reg_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   strobe_t            strb_q, strb_d;
   logic [1:0]         cls;
   logic [3:0]         fn;
   logic               is_halt;

   assign cls     = ir_q[8:7];
   assign fn      = ir_q[6:3];
   assign is_halt = (ir_q[8:0] == HALT_INSTR) && (&ir_q);

   // State, IR and strobe registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         strb_q  <= strb_d;
      end
   end

   // Next state; IR only moves on the fetch handshake
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  if (instr_valid) begin
                       state_d = ST_DECODE;
                       ir_d    = instr;
                    end
         ST_DECODE: state_d = is_halt ? ST_HALT : ST_EXEC;
         ST_EXEC:   case (cls)
                       CLS_R, CLS_I: state_d = ST_WB;
                       CLS_BR:       state_d = ST_FETCH;
                       CLS_MEM:      state_d = ST_MEM;
                       default:      state_d = ST_WB;
                    endcase
         ST_MEM:    state_d = fn[0] ? ST_FETCH : ST_WB;
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   if (start) state_d = ST_FETCH;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Strobes are decided on the transition and registered, so each one is high
   // for exactly the cycle spent in the target state (WB, MEM) or, for branches
   // and pc_clr, the first cycle of the following FETCH.
   always_comb begin
      strb_d = '0;
      case (state_q)
         ST_IDLE, ST_HALT: strb_d.pc_clr = start;
         ST_FETCH:         strb_d.ir_load = instr_valid;
         ST_EXEC: begin
            case (cls)
               CLS_BR: begin
                  // funct[3]=1 is unconditional, otherwise taken on zero
                  strb_d.pc_load = fn[3] | zero;
                  strb_d.pc_inc  = ~(fn[3] | zero);
               end
               CLS_MEM: begin
                  strb_d.mem_re = ~fn[0];
                  strb_d.mem_we = fn[0];
                  strb_d.pc_inc = fn[0];
               end
               default: begin
                  strb_d.reg_we = 1'b1;
                  strb_d.pc_inc = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            strb_d.reg_we = ~fn[0];
            strb_d.pc_inc = ~fn[0];
         end
         default: strb_d = '0;
      endcase
   end

   assign alu_op    = cls;
   assign funct_bit = fn;
   assign pc_clr    = strb_q.pc_clr;
   assign pc_inc    = strb_q.pc_inc;
   assign pc_load   = strb_q.pc_load;
   assign ir_load   = strb_q.ir_load;
   assign reg_we    = strb_q.reg_we;
   assign mem_re    = strb_q.mem_re;
   assign mem_we    = strb_q.mem_we;
   assign halted    = (state_q == ST_HALT);

`ifdef CTRL_PERF_CNT_EN
   // An instruction retires on the edge that leaves its last state
   logic retire;
   assign retire = ((state_q == ST_EXEC) && (cls == CLS_BR)) ||
                   ((state_q == ST_MEM) && fn[0]) ||
                   (state_q == ST_WB);

   retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (retire),
      .count (retired)
   );
`else
   assign retired = '0;
`endif

endmodule
